// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered UART transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Parity bit that makes the total number of ones even (or odd).
  function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] word, input int mode);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is always refused.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmitter fed by a small FIFO; one serial bit per baud clock, frames sent back-to-back.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int P_DATA_BITS  = 8,
  parameter int P_PARITY     = 0,
  parameter int P_STOP_BITS  = 1,
  parameter int P_FIFO_DEPTH = 4
) (
  input  logic                            w_baud_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  input  logic [P_DATA_BITS-1:0]          i_data,
  output logic                            o_ready,
  output logic                            o_tx,
  output logic                            o_busy,
  output logic                            o_idle,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_level
);

  localparam int CW = $clog2(P_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(P_DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(P_STOP_BITS - 1);

  if (P_DATA_BITS < DATA_BITS_MIN || P_DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_buf: P_DATA_BITS must be 5..9");
  end
  if (P_PARITY != PAR_NONE && P_PARITY != PAR_EVEN && P_PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_buf: P_PARITY must be 0, 1 or 2");
  end
  if (P_STOP_BITS < STOP_BITS_MIN || P_STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_buf: P_STOP_BITS must be 1 or 2");
  end
  if (P_FIFO_DEPTH < 2 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buf: P_FIFO_DEPTH must be a power of 2, at least 2");
  end

  tx_state_t              state;
  logic [P_DATA_BITS-1:0] shift;
  logic [CW-1:0]          bit_cnt;
  logic                   stop_cnt;
  logic                   parity;
  logic [P_DATA_BITS-1:0] fifo_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;

  sync_fifo #(
    .WIDTH (P_DATA_BITS),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk       (w_baud_clk),
    .rst_n     (i_rst),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_level)
  );

  // A new word is taken either from IDLE or on the last stop cycle, giving gapless frames.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || (state == STOP && stop_cnt == STOP_LAST));

  assign o_ready = ~fifo_full;
  assign o_idle  = (state == IDLE) && fifo_empty;

  // o_tx and o_busy reflect the state being left at each edge, so they trail the state by one cycle.
  always_ff @(posedge w_baud_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      parity   <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      o_busy <= (state != IDLE);
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
        end
        START: begin
          o_tx  <= 1'b0;
          state <= DATA;
        end
        DATA: begin
          o_tx    <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == BIT_LAST)
            state <= (P_PARITY != PAR_NONE) ? PARITY : STOP;
        end
        PARITY: begin
          o_tx  <= parity;
          state <= STOP;
        end
        STOP: begin
          o_tx <= 1'b1;
          if (stop_cnt == STOP_LAST) begin
            stop_cnt <= 1'b0;
            state    <= IDLE;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= IDLE;
        end
      endcase

      // Parity is latched from the popped word because the shift register is consumed during DATA.
      if (fifo_pop) begin
        state   <= START;
        shift   <= fifo_data;
        bit_cnt <= '0;
        parity  <= parity_of(DATA_BITS_MAX'(fifo_data), P_PARITY);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Drives four differently configured transmitters with shared stimulus and compares them to a frame-queue model.
module tb_uart_tx_buf;

  logic       w_baud_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_data;

  logic [3:0] tx_v, busy_v, idle_v, ready_v;
  logic [2:0] lvl0, lvl2, lvl3;
  logic [3:0] lvl1;

  int compared;
  int mismatched;

  // Configurations: 8N1/d4, 8E1/d8, 8O1/d4, 7E2/d4
  int cfg_bits [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 1, 2, 1};
  int cfg_stop [4] = '{1, 1, 1, 2};
  int cfg_dep  [4] = '{4, 8, 4, 4};

  logic [7:0]  mq [4][8];
  int          mhead [4];
  int          mcount [4];
  logic [15:0] pbits [4];
  int          plen [4];
  logic        exp_tx [4];
  logic        exp_busy [4];

  logic [10:0] cap0, cap1, cap2, cap3;

  always #5 w_baud_clk = ~w_baud_clk;

  uart_tx_buf #(.P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1), .P_FIFO_DEPTH(4)) dut_8n1 (
    .w_baud_clk (w_baud_clk), .i_rst (i_rst), .i_valid (i_valid), .i_data (i_data),
    .o_ready (ready_v[0]), .o_tx (tx_v[0]), .o_busy (busy_v[0]), .o_idle (idle_v[0]), .o_level (lvl0));

  uart_tx_buf #(.P_DATA_BITS(8), .P_PARITY(1), .P_STOP_BITS(1), .P_FIFO_DEPTH(8)) dut_8e1 (
    .w_baud_clk (w_baud_clk), .i_rst (i_rst), .i_valid (i_valid), .i_data (i_data),
    .o_ready (ready_v[1]), .o_tx (tx_v[1]), .o_busy (busy_v[1]), .o_idle (idle_v[1]), .o_level (lvl1));

  uart_tx_buf #(.P_DATA_BITS(8), .P_PARITY(2), .P_STOP_BITS(1), .P_FIFO_DEPTH(4)) dut_8o1 (
    .w_baud_clk (w_baud_clk), .i_rst (i_rst), .i_valid (i_valid), .i_data (i_data),
    .o_ready (ready_v[2]), .o_tx (tx_v[2]), .o_busy (busy_v[2]), .o_idle (idle_v[2]), .o_level (lvl2));

  uart_tx_buf #(.P_DATA_BITS(7), .P_PARITY(1), .P_STOP_BITS(2), .P_FIFO_DEPTH(4)) dut_7e2 (
    .w_baud_clk (w_baud_clk), .i_rst (i_rst), .i_valid (i_valid), .i_data (i_data[6:0]),
    .o_ready (ready_v[3]), .o_tx (tx_v[3]), .o_busy (busy_v[3]), .o_idle (idle_v[3]), .o_level (lvl3));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3:0] levelOf(input int i);
    case (i)
      0:       return {1'b0, lvl0};
      1:       return lvl1;
      2:       return {1'b0, lvl2};
      default: return {1'b0, lvl3};
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mhead[i]    = 0;
      mcount[i]   = 0;
      plen[i]     = 0;
      pbits[i]    = '0;
      exp_tx[i]   = 1'b1;
      exp_busy[i] = 1'b0;
    end
  endtask

  // Whole frame as a bit list, LSB first: start, data, optional parity, stop bits.
  task automatic buildFrame(input int i, input logic [7:0] w);
    logic [15:0] f;
    int          pos;
    logic        ones;
    f    = '1;
    pos  = 0;
    ones = 1'b0;
    f[pos] = 1'b0;
    pos++;
    for (int b = 0; b < cfg_bits[i]; b++) begin
      f[pos] = w[b];
      ones   = ones ^ w[b];
      pos++;
    end
    if (cfg_par[i] != 0) begin
      f[pos] = (cfg_par[i] == 2) ? ~ones : ones;
      pos++;
    end
    for (int s = 0; s < cfg_stop[i]; s++) begin
      f[pos] = 1'b1;
      pos++;
    end
    pbits[i] = f;
    plen[i]  = pos;
  endtask

  // One rising edge: emit the next pending line bit, start a new frame once the line is free.
  task automatic modelEdge(input logic valid, input logic [7:0] data);
    for (int i = 0; i < 4; i++) begin
      logic       push_ok;
      logic [7:0] w;
      push_ok = valid && (mcount[i] < cfg_dep[i]);
      if (plen[i] > 0) begin
        exp_tx[i]   = pbits[i][0];
        pbits[i]    = pbits[i] >> 1;
        plen[i]     = plen[i] - 1;
        exp_busy[i] = 1'b1;
      end else begin
        exp_tx[i]   = 1'b1;
        exp_busy[i] = 1'b0;
      end
      if (plen[i] == 0 && mcount[i] > 0) begin
        w         = mq[i][mhead[i]];
        mhead[i]  = (mhead[i] + 1) % 8;
        mcount[i] = mcount[i] - 1;
        buildFrame(i, w);
      end
      if (push_ok) begin
        mq[i][(mhead[i] + mcount[i]) % 8] = data & 8'((1 << cfg_bits[i]) - 1);
        mcount[i] = mcount[i] + 1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s tx%0d", tag, i), 32'(tx_v[i]), 32'(exp_tx[i]));
      checkOutput($sformatf("%s busy%0d", tag, i), 32'(busy_v[i]), 32'(exp_busy[i]));
      checkOutput($sformatf("%s idle%0d", tag, i), 32'(idle_v[i]), 32'(plen[i] == 0 && mcount[i] == 0));
      checkOutput($sformatf("%s ready%0d", tag, i), 32'(ready_v[i]), 32'(mcount[i] < cfg_dep[i]));
      checkOutput($sformatf("%s level%0d", tag, i), 32'(levelOf(i)), 32'(mcount[i]));
    end
  endtask

  // Called on a falling edge; applies inputs across one rising edge and checks half a cycle later.
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    i_valid = valid;
    i_data  = data;
    @(posedge w_baud_clk);
    modelEdge(valid, data);
    @(negedge w_baud_clk);
    checkAll("run");
  endtask

  task automatic pulseReset();
    #2 i_rst = 1'b0;
    #1 modelReset();
    checkAll("async_rst");
    @(negedge w_baud_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    i_valid    = 1'b0;
    i_data     = '0;
    i_rst      = 1'b1;
    modelReset();
    #1 i_rst = 1'b0;
    #2 checkAll("reset");
    @(negedge w_baud_clk);
    i_rst = 1'b1;

    // Hold valid for six cycles with distinct words, then drain.
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'(8'h10 + k));
    for (int k = 0; k < 80; k++) applyStimulus(1'b0, 8'h00);

    // 0xA5 from idle; a second word is pushed into the empty FIFO on the 8N1 final stop cycle.
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(k == 9, (k == 9) ? 8'h3C : 8'h00);
      cap0[k] = tx_v[0];
      cap1[k] = tx_v[1];
      cap2[k] = tx_v[2];
    end
    checkOutput("frame_8n1_a5", 32'(cap0), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
    checkOutput("frame_8e1_a5", 32'(cap1), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
    checkOutput("frame_8o1_a5", 32'(cap2), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 8'h00);

    // 7E2 with 0x41.
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, 8'h00);
      cap3[k] = tx_v[3];
    end
    checkOutput("frame_7e2_41", 32'(cap3), 32'({2'b11, 1'b0, 7'h41, 1'b0}));
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 8'h00);

    // Reset during the data bits of the second queued frame; nothing may follow afterwards.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'(8'hC0 + k));
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 8'h00);
    pulseReset();
    for (int k = 0; k < 30; k++) applyStimulus(1'b0, 8'h00);

    // Random traffic with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus($urandom_range(0, 99) < 60, 8'($urandom));
      if (k % 700 == 350) pulseReset();
    end
    for (int k = 0; k < 120; k++) applyStimulus(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
